// File: rtl/dma_sched_pkg.sv
// Shared types for the DMA job scheduler: FSM state, job descriptor and the
// capture-time job classification.
package dma_sched_pkg;

  localparam int CL_ADDR_W = 42;
  localparam int JOB_LEN_W = 32;

  typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, RUN, DONE} t_sched_state;

  typedef struct packed {
    logic [CL_ADDR_W-1:0] src;
    logic [CL_ADDR_W-1:0] dst;
    logic [JOB_LEN_W-1:0] len;
  } t_dma_job;

  typedef enum logic [1:0] {JOB_LAUNCH, JOB_EMPTY, JOB_BAD} t_job_class;

  // An empty job completes cleanly; a null address is rejected before the DMA sees it.
  function automatic t_job_class classify_job(t_dma_job job);
    if (job.len == '0) return JOB_EMPTY;
    if (job.src == '0 || job.dst == '0) return JOB_BAD;
    return JOB_LAUNCH;
  endfunction

endpackage

// File: rtl/dma_job_sched_if.sv
// Requester job/done handshake plus the DMA configuration bundle.
interface dma_job_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 42,
  parameter int LEN_W   = 32
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_src;
  logic [NUM_REQ*ADDR_W-1:0] req_dst;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        done_valid;
  logic                      done_err;
  logic                      dma_begin_copy;
  logic [ADDR_W-1:0]         dma_rd_addr;
  logic [ADDR_W-1:0]         dma_wr_addr;
  logic [LEN_W:0]            dma_rd_len;
  logic [LEN_W:0]            dma_wr_len;
  logic                      dma_finished;

  modport slave (
    input  req_valid, req_src, req_dst, req_len, dma_finished,
    output req_ready, done_valid, done_err, dma_begin_copy,
           dma_rd_addr, dma_wr_addr, dma_rd_len, dma_wr_len
  );

  modport master (
    output req_valid, req_src, req_dst, req_len, dma_finished,
    input  req_ready, done_valid, done_err, dma_begin_copy,
           dma_rd_addr, dma_wr_addr, dma_rd_len, dma_wr_len
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int j;

  // Scan farthest-first so the last hit, closest to the pointer, is the one kept.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[j]) begin
        gnt_o = NUM_REQ'(1) << j;
        idx_o = IDX_W'(j);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_job_sched.sv
// Round-robin job scheduler in front of a single-channel copy DMA: grants one
// job, programs and starts the DMA, waits for finish or watchdog, reports done.
//
//  state  | meaning
//  IDLE   | arbitrating; req_ready driven for the winner
//  LAUNCH | begin_copy pulse, DMA config driven from the captured job
//  SETTLE | SETTLE_CYC cycles ignoring the stale finished level
//  RUN    | waiting for dma_finished, watchdog counting
//  DONE   | done pulse to owner, DMA addresses back to zero
module dma_job_sched
  import dma_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = CL_ADDR_W,
  parameter int LEN_W      = JOB_LEN_W,
  parameter int SETTLE_CYC = 3,
  parameter int TIMEOUT_W  = 24
) (
  input  logic                       clk,
  input  logic                       Resetb,
  dma_job_sched_if.slave             bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_owner,
  output logic [31:0]                jobs_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int STL_W = $clog2(SETTLE_CYC + 1);

  t_sched_state         state_q;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d, owner_q, win_idx;
  logic [NUM_REQ-1:0]   win_gnt, done_valid_q;
  logic                 win_any, xfer, done_err_q, begin_q;
  logic [ADDR_W-1:0]    rd_addr_q, wr_addr_q;
  logic [LEN_W:0]       len_q;
  logic [STL_W-1:0]     settle_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic [31:0]          jobs_q;
  t_dma_job             job_in;
  t_job_class           job_cls;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Ready is gated by reset so nobody sees an accept that the FSM will drop.
  assign xfer          = (state_q == IDLE) && Resetb && win_any;
  assign bus.req_ready = xfer ? win_gnt : '0;
  assign rr_ptr_d      = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;

  always_comb begin
    job_in.src = CL_ADDR_W'(bus.req_src[int'(win_idx)*ADDR_W +: ADDR_W]);
    job_in.dst = CL_ADDR_W'(bus.req_dst[int'(win_idx)*ADDR_W +: ADDR_W]);
    job_in.len = JOB_LEN_W'(bus.req_len[int'(win_idx)*LEN_W +: LEN_W]);
  end

  assign job_cls = classify_job(job_in);

  always_ff @(posedge clk) begin
    if (!Resetb) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      done_valid_q <= '0;
      done_err_q   <= 1'b0;
      begin_q      <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      len_q        <= '0;
      settle_q     <= '0;
      wd_q         <= '0;
      jobs_q       <= '0;
    end else begin
      begin_q      <= 1'b0;
      done_valid_q <= '0;
      done_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            owner_q  <= win_idx;
            rr_ptr_q <= rr_ptr_d;
            if (job_cls == JOB_LAUNCH) begin
              state_q   <= LAUNCH;
              begin_q   <= 1'b1;
              rd_addr_q <= ADDR_W'(job_in.src);
              wr_addr_q <= ADDR_W'(job_in.dst);
              len_q     <= {1'b0, LEN_W'(job_in.len)};
            end else begin
              state_q      <= DONE;
              done_valid_q <= win_gnt;
              done_err_q   <= (job_cls == JOB_BAD);
              jobs_q       <= jobs_q + 32'd1;
            end
          end
        end
        LAUNCH: begin
          state_q  <= SETTLE;
          settle_q <= STL_W'(SETTLE_CYC - 1);
          wd_q     <= '0;
        end
        SETTLE: begin
          if (settle_q == '0) state_q <= RUN;
          else                settle_q <= settle_q - 1'b1;
        end
        RUN: begin
          // Finished takes priority over a watchdog expiring in the same cycle.
          if (bus.dma_finished || (&wd_q)) begin
            state_q      <= DONE;
            done_valid_q <= NUM_REQ'(1) << owner_q;
            done_err_q   <= !bus.dma_finished;
            jobs_q       <= jobs_q + 32'd1;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            len_q        <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dma_begin_copy = begin_q;
  assign bus.dma_rd_addr    = rd_addr_q;
  assign bus.dma_wr_addr    = wr_addr_q;
  assign bus.dma_rd_len     = len_q;
  assign bus.dma_wr_len     = len_q;
  assign bus.done_valid     = done_valid_q;
  assign bus.done_err       = done_err_q;
  assign busy               = (state_q != IDLE);
  assign cur_owner          = owner_q;
  assign jobs_done          = jobs_q;

endmodule

// File: tb/tb_dma_job_sched.sv
// Bench for dma_job_sched: job-timeline model checked every cycle, plus
// directed scenarios pinned with hand-computed latencies and grant orders.
module tb_dma_job_sched;

  localparam int N  = 4;
  localparam int AW = 42;
  localparam int LW = 32;
  localparam int S  = 3;
  localparam int TW = 6;

  logic        clk = 1'b0;
  logic        Resetb;
  logic        busy;
  logic [1:0]  cur_owner;
  logic [31:0] jobs_done;

  dma_job_sched_if #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW)) bus ();

  dma_job_sched #(
    .NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .SETTLE_CYC(S), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .Resetb(Resetb), .bus(bus),
    .busy(busy), .cur_owner(cur_owner), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;

  // Job-level model: one job in flight, described by its launch and done cycles.
  bit          armed = 0, m_inflt = 0, m_launched = 0, m_err = 0;
  int          m_owner = 0, m_ptr = 0, m_launch = 0, m_done = -1, w;
  logic [AW-1:0] m_src, m_dst;
  logic [LW-1:0] m_len;
  logic [31:0]   m_jobs = 0;

  logic [N-1:0]  e_ready, e_done;
  logic [AW-1:0] e_rd, e_wr;
  logic [LW:0]   e_len;
  bit            live, e_begin, e_derr;

  int       rec_begin = 0, rec_done = 0, n_begin = 0, n_done = 0;
  bit       rec_err = 0;
  logic [N-1:0] rec_vec = '0;
  int       grants[$];
  int       exp_order[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s cyc=%0d actual=no-event required=event", nm, cyc);
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      w       = pick();
      e_ready = (!m_inflt && Resetb && w >= 0) ? (N'(1) << w) : '0;
      live    = m_inflt && m_launched && (m_done < 0 || cyc < m_done);
      e_begin = m_inflt && m_launched && (cyc == m_launch);
      e_rd    = live ? m_src : '0;
      e_wr    = live ? m_dst : '0;
      e_len   = live ? {1'b0, m_len} : '0;
      e_done  = (m_inflt && cyc == m_done) ? (N'(1) << m_owner) : '0;
      e_derr  = m_inflt && (cyc == m_done) && m_err;
      chk("req_ready",  64'(bus.req_ready),      64'(e_ready));
      chk("done_valid", 64'(bus.done_valid),     64'(e_done));
      chk("done_err",   64'(bus.done_err),       64'(e_derr));
      chk("begin_copy", 64'(bus.dma_begin_copy), 64'(e_begin));
      chk("rd_addr",    64'(bus.dma_rd_addr),    64'(e_rd));
      chk("wr_addr",    64'(bus.dma_wr_addr),    64'(e_wr));
      chk("rd_len",     64'(bus.dma_rd_len),     64'(e_len));
      chk("wr_len",     64'(bus.dma_wr_len),     64'(e_len));
      chk("busy",       64'(busy),               64'(m_inflt));
      chk("cur_owner",  64'(cur_owner),          64'(m_owner));
      chk("jobs_done",  64'(jobs_done),          64'(m_jobs));
      if (bus.dma_begin_copy) begin n_begin++; rec_begin = cyc; end
      if (|bus.done_valid) begin
        n_done++; rec_done = cyc; rec_err = bus.done_err; rec_vec = bus.done_valid;
      end
      for (int i = 0; i < N; i++)
        if (bus.req_ready[i] && bus.req_valid[i]) grants.push_back(i);
    end
    if (!Resetb) begin
      armed = 1; m_inflt = 0; m_ptr = 0; m_owner = 0; m_jobs = 0;
      m_done = -1; m_launched = 0; m_err = 0;
    end else if (armed) begin
      if (m_inflt && cyc == m_done) begin
        m_inflt = 0;
      end else if (!m_inflt) begin
        w = pick();
        if (w >= 0) begin
          m_inflt = 1; m_owner = w; m_ptr = (w + 1) % N;
          m_src = bus.req_src[w*AW +: AW];
          m_dst = bus.req_dst[w*AW +: AW];
          m_len = bus.req_len[w*LW +: LW];
          if (m_len == 0) begin
            m_launched = 0; m_err = 0; m_done = cyc + 1;
          end else if (m_src == 0 || m_dst == 0) begin
            m_launched = 0; m_err = 1; m_done = cyc + 1;
          end else begin
            m_launched = 1; m_launch = cyc + 1; m_done = -1;
          end
        end
      end else if (m_launched && m_done < 0 && cyc >= m_launch + 1 + S) begin
        if (bus.dma_finished) begin
          m_done = cyc + 1; m_err = 0;
        end else if (cyc - (m_launch + 1 + S) == (1 << TW) - 1) begin
          m_done = cyc + 1; m_err = 1;
        end
      end
      if (m_inflt && m_done == cyc + 1) m_jobs++;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic submit(input int r, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [LW-1:0] l);
    bus.req_src[r*AW +: AW] = s;
    bus.req_dst[r*AW +: AW] = d;
    bus.req_len[r*LW +: LW] = l;
    bus.req_valid[r] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (bus.req_ready[r]) begin
        tick();
        bus.req_valid[r] = 1'b0;
        return;
      end
      tick();
    end
    bus.req_valid[r] = 1'b0;
    bound_fail("submit_grant");
  endtask

  task automatic wait_begin();
    for (int i = 0; i < 200; i++) begin
      if (bus.dma_begin_copy) return;
      tick();
    end
    bound_fail("wait_begin");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (|bus.done_valid) begin
        bus.dma_finished = 1'b0;
        tick();
        return;
      end
      tick();
    end
    bus.dma_finished = 1'b0;
    bound_fail("wait_done");
  endtask

  task automatic do_reset();
    Resetb = 1'b0;
    tick();
    Resetb = 1'b1;
    tick();
  endtask

  initial begin
    exp_order = '{0, 1, 2, 3, 0};
    Resetb = 1'b0;
    bus.req_valid = '0;
    bus.req_src = '0;
    bus.req_dst = '0;
    bus.req_len = '0;
    bus.dma_finished = 1'b0;
    repeat (3) tick();
    Resetb = 1'b1;
    tick();
    chk("reset_jobs", 64'(jobs_done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // Single job, finished 40 cycles after begin
    submit(0, 42'h1000, 42'h2000, 32'd16);
    wait_begin();
    repeat (40) tick();
    bus.dma_finished = 1'b1;
    wait_done();
    chk("t1_latency", 64'(rec_done - rec_begin), 64'd41);
    chk("t1_err", 64'(rec_err), 64'd0);
    chk("t1_owner", 64'(rec_vec), 64'b0001);
    chk("t1_jobs", 64'(jobs_done), 64'd1);
    chk("t1_begins", 64'(n_begin), 64'd1);

    // All requesters valid: grant order from a fresh pointer
    do_reset();
    grants.delete();
    n_begin = 0;
    for (int i = 0; i < N; i++) begin
      bus.req_src[i*AW +: AW] = 42'h100 + 42'(i);
      bus.req_dst[i*AW +: AW] = 42'h200 + 42'(i);
      bus.req_len[i*LW +: LW] = 32'd4;
    end
    bus.req_valid = '1;
    for (int j = 0; j < 5; j++) begin
      wait_begin();
      if (j == 4) bus.req_valid = '0;
      repeat (10) tick();
      bus.dma_finished = 1'b1;
      wait_done();
    end
    chk("t2_grant_count", 64'(grants.size()), 64'd5);
    for (int j = 0; j < 5; j++)
      if (j < grants.size()) chk("t2_grant_order", 64'(grants[j]), 64'(exp_order[j]));
    chk("t2_begins", 64'(n_begin), 64'd5);
    chk("t2_jobs", 64'(jobs_done), 64'd5);

    // Stale finished held through launch and settle
    bus.dma_finished = 1'b1;
    submit(1, 42'h3000, 42'h4000, 32'd8);
    wait_begin();
    repeat (4) tick();
    bus.dma_finished = 1'b0;
    repeat (20) tick();
    bus.dma_finished = 1'b1;
    wait_done();
    chk("t3_latency", 64'(rec_done - rec_begin), 64'd25);
    chk("t3_owner", 64'(rec_vec), 64'b0010);

    // Empty job and null-source job never touch the DMA
    n_begin = 0;
    submit(2, 42'h5000, 42'h6000, 32'd0);
    wait_done();
    chk("t4_empty_err", 64'(rec_err), 64'd0);
    chk("t4_empty_owner", 64'(rec_vec), 64'b0100);
    submit(3, 42'h0, 42'h7000, 32'd5);
    wait_done();
    chk("t4_null_err", 64'(rec_err), 64'd1);
    chk("t4_null_owner", 64'(rec_vec), 64'b1000);
    chk("t4_no_begin", 64'(n_begin), 64'd0);

    // Watchdog expiry, then a normal job
    submit(0, 42'h8000, 42'h9000, 32'd7);
    wait_begin();
    wait_done();
    chk("t5_timeout_latency", 64'(rec_done - rec_begin), 64'd68);
    chk("t5_timeout_err", 64'(rec_err), 64'd1);
    submit(1, 42'hA000, 42'hB000, 32'd3);
    wait_begin();
    repeat (5) tick();
    bus.dma_finished = 1'b1;
    wait_done();
    chk("t5_next_latency", 64'(rec_done - rec_begin), 64'd6);
    chk("t5_next_err", 64'(rec_err), 64'd0);

    // Reset during RUN aborts silently
    submit(2, 42'hC000, 42'hD000, 32'd9);
    wait_begin();
    repeat (6) tick();
    n_done = 0;
    Resetb = 1'b0;
    tick();
    Resetb = 1'b1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_rd_addr", 64'(bus.dma_rd_addr), 64'd0);
    repeat (10) tick();
    chk("t6_no_done", 64'(n_done), 64'd0);
    submit(1, 42'hE000, 42'hF000, 32'd2);
    wait_begin();
    repeat (8) tick();
    bus.dma_finished = 1'b1;
    wait_done();
    chk("t6_after_err", 64'(rec_err), 64'd0);
    chk("t6_after_owner", 64'(rec_vec), 64'b0010);
    chk("t6_after_jobs", 64'(jobs_done), 64'd1);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/dma_job_sched.md
Name: dma_job_sched

Overview:
- Job scheduler in front of the single-channel copy DMA engine.
- Accepts copy jobs (source cache-line address, destination cache-line address, length in lines) from NUM_REQ requesters and arbitrates among them round-robin.
- Programs the DMA configuration inputs, pulses begin_copy, waits for the DMA finished indication (or a timeout), then reports completion to the owning requester.
- Sits between the AFU's job sources and the DMA's configuration bundle; the DMA runs only one job at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 42, cache-line address width (matches t_ccip_clAddr).
- LEN_W, 32, job length width in cache lines.
- SETTLE_CYC, 3, cycles after begin_copy during which dma_finished is ignored.
- TIMEOUT_W, 24, width of the per-job watchdog counter; timeout fires at all-ones.

Ports:
- clk  in  1  clock.
- Resetb  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester job valid.
- req_ready  out  NUM_REQ  per-requester accept; a job transfers on valid&&ready.
- req_src  in  NUM_REQ*ADDR_W  source addresses, packed.
- req_dst  in  NUM_REQ*ADDR_W  destination addresses, packed.
- req_len  in  NUM_REQ*LEN_W  lengths, packed.
- done_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- done_err  out  1  qualifies done_valid: 1 = timeout or rejected job.
- dma_begin_copy  out  1  one-cycle pulse that restarts the DMA.
- dma_rd_addr  out  ADDR_W  DMA source address.
- dma_wr_addr  out  ADDR_W  DMA destination address.
- dma_rd_len  out  LEN_W+1  DMA read length.
- dma_wr_len  out  LEN_W+1  DMA write length.
- dma_finished  in  1  DMA completion level.
- busy  out  1  state != IDLE.
- cur_owner  out  clog2(NUM_REQ)  index of the active job's requester.
- jobs_done  out  32  count of completed jobs (ok or err); wraps.

Behaviour:
- Reset (Resetb=0 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - All outputs 0, including dma_rd_addr/dma_wr_addr. Zero addresses keep the DMA idle.
- Arbitration (IDLE only):
  - Round-robin search starts at rr_ptr. The winner w gets req_ready[w]=1 for exactly that cycle (combinational from state==IDLE and the arbiter result). All other ready bits are 0.
  - On transfer: latch src/dst/len, set cur_owner=w, rr_ptr=(w+1) mod NUM_REQ.
- Job checks at capture:
  - len==0: go to DONE with done_err=0. The DMA is not touched.
  - src==0 or dst==0: go to DONE with done_err=1. The DMA is not touched.
  - Otherwise go to LAUNCH.
- LAUNCH (1 cycle):
  - dma_begin_copy=1.
  - Drive dma_rd_addr=src, dma_wr_addr=dst, dma_rd_len=dma_wr_len=zero-extended len. These are held stable until DONE.
  - Clear the watchdog. Go to SETTLE.
- SETTLE:
  - Count SETTLE_CYC cycles while ignoring dma_finished. This masks the stale finished level left over from the previous job across the DMA's registered reset.
  - Then go to RUN.
- RUN:
  - Watchdog increments each cycle.
  - dma_finished=1: go to DONE, err=0.
  - Watchdog all-ones: go to DONE, err=1.
  - If both happen in the same cycle, finished wins (err=0).
- DONE (1 cycle):
  - done_valid[cur_owner]=1, done_err per cause, jobs_done+=1.
  - Drive dma_rd_addr/dma_wr_addr to 0 so the DMA returns idle. Go to IDLE.
  - A new job can be granted no earlier than the cycle after DONE.
- Minimum latency, valid job: grant→LAUNCH 1, →RUN 1+SETTLE_CYC, →done pulse 1 cycle after finished is sampled in RUN.
- Requester holding valid: never starved. It is granted within NUM_REQ jobs.
- Changes to req_* while not granted are ignored. Captured job fields are immune to later input changes.
- Reset mid-job: returns to IDLE within one cycle. No done pulse for the aborted job. DMA addresses go to 0.
- dma_begin_copy is asserted only in LAUNCH, never two cycles in a row.

Decomposition:
- Shared package dma_sched_pkg:
  - t_sched_state enum {IDLE, LAUNCH, SETTLE, RUN, DONE}.
  - t_dma_job struct {src, dst, len}.
- Sub-module rr_arbiter (NUM_REQ request vector, pointer in, one-hot grant and index out), purely combinational; it is reusable by other AFU blocks.

Test Plan:
- Single job: req 0, src=0x1000, dst=0x2000, len=16; finished raised 40 cycles after begin → one begin pulse, addrs/len held through RUN, done_valid[0] with err=0, jobs_done=1, addrs return to 0.
- All 4 requesters valid continuously with len=4 each; finished after 10 cycles → grant order 0,1,2,3,0; exactly one job in flight at any time.
- Stale finished: dma_finished held 1 across LAUNCH and SETTLE, then low for 20 cycles → no done during SETTLE; done only on the next rising finished in RUN.
- len=0 from req 2 → done_valid[2], err=0, no dma_begin_copy; src=0 → done_err=1, no begin.
- Timeout with TIMEOUT_W=6, finished never asserted → done_err=1 after 63 RUN cycles; next job then launches normally.
- Resetb=0 during RUN → next cycle all outputs 0, state IDLE, no done pulse; a job submitted after reset completes correctly.
